// File: rtl/demux_gate_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux_gate_pkg
// Brief    : Shared types, op encodings and helpers for the demux gate arbiter.
// Revision : 1.0
// ============================================================================
package demux_gate_pkg;

    localparam logic OP_NOR  = 1'b0;
    localparam logic OP_NAND = 1'b1;
    localparam int   MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    // 1:2 demux primitive: bit 0 carries d when s=0, bit 1 carries d when s=1.
    function automatic logic [1:0] demux_1to2(input logic d, input logic s);
        return {d & s, d & ~s};
    endfunction

    // First set bit at or above ptr, wrapping at num. Descending scan so the
    // smallest offset from ptr is the last (winning) assignment.
    function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                           input logic [2:0]         ptr,
                                           input int                 num);
        logic [2:0] pick;
        int         idx;
        pick = 3'd0;
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (i < num) begin
                idx = (int'(ptr) + i) % num;
                if (req[idx[2:0]]) begin
                    pick = idx[2:0];
                end
            end
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/demux_universal_gate.sv
`default_nettype none
// ============================================================================
// Module   : demux_universal_gate
// Brief    : Combinational NOR/NAND gate built only from 1:2 demux primitives.
// Revision : 1.0
// ============================================================================
module demux_universal_gate
    import demux_gate_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic op,
    output logic y
);

    logic [1:0] w_inv_a;
    logic [1:0] w_and;
    logic [1:0] w_nand;
    logic [1:0] w_nor;
    logic [1:0] w_sel_nor;
    logic [1:0] w_sel_nand;
    logic       w_unused_legs;

    // A constant-1 data input turns a demux leg into an inverter of its select.
    assign w_inv_a    = demux_1to2(1'b1, a);
    assign w_and      = demux_1to2(a, b);
    assign w_nand     = demux_1to2(1'b1, w_and[1]);
    assign w_nor      = demux_1to2(w_inv_a[0], b);
    assign w_sel_nor  = demux_1to2(w_nor[0], op);
    assign w_sel_nand = demux_1to2(w_nand[0], op);

    assign y = w_sel_nor[0] | w_sel_nand[1];

    assign w_unused_legs = ^{w_inv_a[1], w_and[0], w_nand[1], w_nor[1],
                             w_sel_nor[1], w_sel_nand[0]};

endmodule
`default_nettype wire

// File: rtl/demux_gate_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : demux_gate_arbiter
// Brief    : Round-robin arbiter sharing one demux universal gate between
//            NUM_REQ requesters. Optional DEMUX_GATE_XCHK_EN adds xchk_err.
// Revision : 1.0
// ============================================================================
module demux_gate_arbiter
    import demux_gate_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int SETTLE_CYCLES = 1,
    parameter int ID_W          = $clog2(NUM_REQ)
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] op,
    input  logic [NUM_REQ-1:0] a_in,
    input  logic [NUM_REQ-1:0] b_in,
    output logic [NUM_REQ-1:0] ack,
    output logic               result,
    output logic               busy,
    output logic [ID_W-1:0]    gnt_id
`ifdef DEMUX_GATE_XCHK_EN
    ,
    output logic               xchk_err
`endif
);

    localparam int               c_CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(SETTLE_CYCLES - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ID_W-1:0]      r_ptr;
    logic [ID_W-1:0]      r_gnt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_a;
    logic                 r_b;
    logic                 r_op;
    logic                 r_result;

    logic                 w_gate_y;
    logic [NUM_REQ-1:0]   w_req_eff;
    logic [ID_W-1:0]      w_gnt_inc;
    logic [ID_W-1:0]      w_ptr_arb;
    logic [2:0]           w_pick_full;
    logic [ID_W-1:0]      w_pick;
    logic                 w_arb_state;
    logic                 w_grant;
    logic                 w_capture;
    logic                 w_unused_pick;

    // In RESPOND the requester being acked is masked and the pointer has
    // already moved past it, so arbitration here sees the post-service view.
    assign w_gnt_inc   = (r_gnt == ID_W'(NUM_REQ - 1)) ? '0 : r_gnt + 1'b1;
    assign w_arb_state = (r_state == IDLE) || (r_state == RESPOND);
    assign w_req_eff   = (r_state == RESPOND) ? (req & ~ack) : req;
    assign w_ptr_arb   = (r_state == RESPOND) ? w_gnt_inc : r_ptr;
    assign w_pick_full = rr_pick(MAX_REQ'(w_req_eff), 3'(w_ptr_arb), NUM_REQ);
    assign w_pick      = w_pick_full[ID_W-1:0];
    assign w_grant     = w_arb_state && (|w_req_eff);
    assign w_capture   = (r_state == SETTLE) && (r_cnt == '0);

    assign w_unused_pick = ^w_pick_full;

    demux_universal_gate u_gate (
        .a  (r_a),
        .b  (r_b),
        .op (r_op),
        .y  (w_gate_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ack         = '0;
        busy        = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (w_capture) begin
                    w_state_nxt = RESPOND;
                end
            end
            RESPOND: begin
                ack[r_gnt]  = 1'b1;
                w_state_nxt = w_grant ? SETTLE : IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr    <= '0;
            r_gnt    <= '0;
            r_cnt    <= '0;
            r_a      <= 1'b0;
            r_b      <= 1'b0;
            r_op     <= OP_NOR;
            r_result <= 1'b0;
        end else begin
            if (w_grant) begin
                r_a   <= a_in[w_pick];
                r_b   <= b_in[w_pick];
                r_op  <= op[w_pick];
                r_gnt <= w_pick;
                r_cnt <= c_CNT_INIT;
            end else if ((r_state == SETTLE) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_capture) begin
                r_result <= w_gate_y;
            end
            if (r_state == RESPOND) begin
                r_ptr <= w_gnt_inc;
            end
        end
    end

    assign result = r_result;
    assign gnt_id = r_gnt;

`ifdef DEMUX_GATE_XCHK_EN
    logic r_xchk_err;
    logic w_ref_y;

    assign w_ref_y = (r_op == OP_NAND) ? ~(r_a & r_b) : ~(r_a | r_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xchk_err <= 1'b0;
        end else if (w_capture && (w_gate_y != w_ref_y)) begin
            r_xchk_err <= 1'b1;
        end
    end

    assign xchk_err = r_xchk_err;
`endif

endmodule
`default_nettype wire
